// File: rtl/pwm_capture.sv
// pwm_capture: measures the period and high time of an incoming PWM
// waveform in sample ticks (cycles with enable=1).
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   enable       sample tick; edge detection, counters and the FSM only
//                advance when it is high (tie high to count at clk rate)
//   pwm_in       asynchronous PWM input
//   period       last measured period in ticks, saturated at MAX_COUNT
//   high_time    last measured high time in ticks
//   valid        one-clk pulse when period/high_time update
//   timeout      sticky: no edge seen within MAX_COUNT ticks
//   stuck_level  line level when timeout was raised
//   fsm_state_o  current FSM state (0=SYNC, 1=HIGH, 2=LOW) for observation
//
// Optional build macro PWM_CAPTURE_FILTER_EN adds a glitch filter between
// the synchronizer and the level register: a new level is accepted only
// after FILT_LEN consecutive enable samples of that value. Both edges are
// delayed equally, so clean measurements are unchanged.
//
// Handshake: valid is a pure strobe with no ready; period/high_time are
// stable from the valid cycle until the next valid or reset.

module pwm_capture #(
   parameter int MAX_COUNT = 1024,
   parameter int FILT_LEN  = 3,
   localparam int W        = $clog2(MAX_COUNT + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic         pwm_in,
   output logic [W-1:0] period,
   output logic [W-1:0] high_time,
   output logic         valid,
   output logic         timeout,
   output logic         stuck_level,
   output logic [1:0]   fsm_state_o
);

   localparam logic [W-1:0] MAX_W   = W'(MAX_COUNT);
   localparam logic [W:0]   MAX_SUM = (W+1)'(MAX_COUNT);

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_e;

   state_e       state_q, state_d;
   logic         sync1_q, sync2_q;
   logic         lvl_q;
   logic         samp;          // level that lvl_q takes on this enable cycle
   logic         rise, fall;
   logic         capture;       // LOW->HIGH edge completes a measurement
   logic         tmo_set;       // count hit MAX_COUNT with no edge
   logic [W-1:0] hcnt_q, hcnt_d;
   logic [W-1:0] lcnt_q, lcnt_d;
   logic [W-1:0] period_q, period_d;
   logic [W-1:0] high_q, high_d;
   logic         valid_q;
   logic         tmo_q, tmo_d;
   logic         stuck_q, stuck_d;
   logic [W:0]   sum;

   // Two-flop synchronizer, free-running regardless of enable.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= pwm_in;
         sync2_q <= sync1_q;
      end
   end

`ifdef PWM_CAPTURE_FILTER_EN
   localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [FW-1:0] RUN_LAST = FW'(FILT_LEN - 1);

   // run_q counts consecutive enable samples that differ from lvl_q; the new
   // level is accepted on the FILT_LEN-th such sample.
   logic [FW-1:0] run_q, run_d;

   always_comb begin
      samp  = lvl_q;
      run_d = run_q;
      if (enable) begin
         if (sync2_q == lvl_q) begin
            run_d = '0;
         end else if (run_q == RUN_LAST) begin
            samp  = sync2_q;
            run_d = '0;
         end else begin
            run_d = run_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         run_q <= '0;
      end else begin
         run_q <= run_d;
      end
   end
`else
   logic filt_unused;
   assign filt_unused = (FILT_LEN > 0);
   assign samp        = sync2_q;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         lvl_q <= 1'b0;
      end else if (enable) begin
         lvl_q <= samp;
      end
   end

   assign rise = enable &  samp & ~lvl_q;
   assign fall = enable & ~samp &  lvl_q;

   // State and measurement registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_SYNC;
         hcnt_q   <= '0;
         lcnt_q   <= '0;
         period_q <= '0;
         high_q   <= '0;
         valid_q  <= 1'b0;
         tmo_q    <= 1'b0;
         stuck_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         hcnt_q   <= hcnt_d;
         lcnt_q   <= lcnt_d;
         period_q <= period_d;
         high_q   <= high_d;
         valid_q  <= capture;
         tmo_q    <= tmo_d;
         stuck_q  <= stuck_d;
      end
   end

   // Next-state logic. A counter already at MAX_COUNT on a tick with no edge
   // times out; an edge on that same tick wins, so a phase of exactly
   // MAX_COUNT ticks is still measured. Because the timeout fires before any
   // increment past MAX_COUNT, the increments never need their own clamp.
   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      lcnt_d  = lcnt_q;
      capture = 1'b0;
      tmo_set = 1'b0;
      case (state_q)
         ST_SYNC: begin
            if (rise) begin
               state_d = ST_HIGH;
               hcnt_d  = W'(1);
            end
         end
         ST_HIGH: begin
            if (fall) begin
               state_d = ST_LOW;
               lcnt_d  = W'(1);
            end else if (enable) begin
               if (hcnt_q == MAX_W) begin
                  tmo_set = 1'b1;
                  state_d = ST_SYNC;
               end else begin
                  hcnt_d = hcnt_q + 1'b1;
               end
            end
         end
         ST_LOW: begin
            if (rise) begin
               capture = 1'b1;
               state_d = ST_HIGH;
               hcnt_d  = W'(1);
            end else if (enable) begin
               if (lcnt_q == MAX_W) begin
                  tmo_set = 1'b1;
                  state_d = ST_SYNC;
               end else begin
                  lcnt_d = lcnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_SYNC;
         end
      endcase
   end

   // Output logic: result registers update on capture, timeout flags on
   // capture (clear) or timeout (set).
   always_comb begin
      sum      = {1'b0, hcnt_q} + {1'b0, lcnt_q};
      period_d = period_q;
      high_d   = high_q;
      tmo_d    = tmo_q;
      stuck_d  = stuck_q;
      if (capture) begin
         period_d = (sum > MAX_SUM) ? MAX_W : sum[W-1:0];
         high_d   = hcnt_q;
         tmo_d    = 1'b0;
      end else if (tmo_set) begin
         tmo_d   = 1'b1;
         stuck_d = lvl_q;
      end
   end

   assign period      = period_q;
   assign high_time   = high_q;
   assign valid       = valid_q;
   assign timeout     = tmo_q;
   assign stuck_level = stuck_q;
   assign fsm_state_o = state_q;

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

  localparam int MAX_COUNT = 1024;
  localparam int W = $clog2(MAX_COUNT + 1);

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         pwm_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         timeout;
  logic         stuck_level;
  logic [1:0]   fsm_state;

  int n_checks = 0;
  int n_fail = 0;
  int n_valid = 0;
  int cyc = 0;
  int last_valid = -1;
  bit gap_chk = 1'b0;
  bit en_mode = 1'b0;
  int v0;

  // expected {period, high_time} per valid strobe, in order
  logic [2*W-1:0] exp_q[$];

  pwm_capture #(
    .MAX_COUNT(MAX_COUNT),
    .FILT_LEN (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .period     (period),
    .high_time  (high_time),
    .valid      (valid),
    .timeout    (timeout),
    .stuck_level(stuck_level),
    .fsm_state_o(fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_period", 32'(period), 0);
    check_eq("rst_high_time", 32'(high_time), 0);
    check_eq("rst_valid", 32'(valid), 0);
    check_eq("rst_timeout", 32'(timeout), 0);
    check_eq("rst_stuck_level", 32'(stuck_level), 0);
    check_eq("rst_state", 32'(fsm_state), 0);
    reset = 1'b1;
  endtask

  task automatic drive(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_meas(input int p, input int h);
    exp_q.push_back({W'(p), W'(h)});
  endtask

  // enable generator: always high, or one clk in four
  initial begin : en_gen
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      if (en_mode) begin
        enable = (div == 3);
        div = (div + 1) % 4;
      end else begin
        enable = 1'b1;
      end
    end
  end

  // scoreboard
  initial begin : monitor
    logic [2*W-1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (valid === 1'b1) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("period", 32'(period), 32'(e[2*W-1:W]));
          check_eq("high_time", 32'(high_time), 32'(e[W-1:0]));
          check_eq("timeout_at_valid", 32'(timeout), 0);
        end
        if (gap_chk && last_valid >= 0) check_eq("valid_gap", cyc - last_valid, 100);
        last_valid = cyc;
      end
    end
  end

  initial begin
    reset  = 1'b0;
    enable = 1'b1;
    pwm_in = 1'b0;
    apply_reset();

    // 30/70 at clk rate, three full periods
    gap_chk = 1'b1;
    last_valid = -1;
    v0 = n_valid;
    drive(0, 10);
    repeat (3) begin
      expect_meas(100, 30);
      drive(1, 30);
      drive(0, 70);
    end
    drive(1, 30);
    drive(0, 20);
    gap_chk = 1'b0;
    check_eq("t1_valid_count", n_valid - v0, 3);
    check_eq("t1_drained", exp_q.size(), 0);
    check_eq("t1_timeout", 32'(timeout), 0);

    // enable every 4th clk, 40/40 clk
    en_mode = 1'b1;
    apply_reset();
    v0 = n_valid;
    drive(0, 40);
    repeat (3) begin
      expect_meas(20, 10);
      drive(1, 40);
      drive(0, 40);
    end
    drive(1, 40);
    drive(0, 40);
    check_eq("t2_valid_count", n_valid - v0, 3);
    check_eq("t2_drained", exp_q.size(), 0);
    en_mode = 1'b0;

    // stuck high after one capture -> timeout, then recovery
    apply_reset();
    drive(0, 10);
    expect_meas(100, 30);
    drive(1, 30);
    drive(0, 70);
    drive(1, 1020);
    check_eq("t3_no_early_timeout", 32'(timeout), 0);
    drive(1, 20);
    check_eq("t3_timeout", 32'(timeout), 1);
    check_eq("t3_stuck_level", 32'(stuck_level), 1);
    check_eq("t3_period_kept", 32'(period), 100);
    check_eq("t3_high_kept", 32'(high_time), 30);
    check_eq("t3_state_sync", 32'(fsm_state), 0);
    drive(0, 50);
    check_eq("t3_timeout_sticky", 32'(timeout), 1);
    expect_meas(100, 30);
    drive(1, 30);
    drive(0, 70);
    drive(1, 10);
    check_eq("t3_timeout_cleared", 32'(timeout), 0);
    check_eq("t3_drained", exp_q.size(), 0);

    // reset in the middle of the LOW phase
    apply_reset();
    drive(0, 10);
    expect_meas(100, 30);
    drive(1, 30);
    drive(0, 70);
    drive(1, 30);
    drive(0, 35);
    check_eq("t4_pre_period", 32'(period), 100);
    check_eq("t4_pre_state_low", 32'(fsm_state), 2);
    apply_reset();
    v0 = n_valid;
    drive(0, 35);
    drive(1, 30);
    drive(0, 70);
    check_eq("t4_no_valid_after_reset", n_valid - v0, 0);
    expect_meas(100, 30);
    drive(1, 10);
    check_eq("t4_drained", exp_q.size(), 0);

    // 2-clk low glitch inside the high phase
    apply_reset();
    drive(0, 10);
    expect_meas(100, 30);
    drive(1, 30);
    drive(0, 70);
`ifdef PWM_CAPTURE_FILTER_EN
    expect_meas(100, 30);
`else
    expect_meas(12, 10);
    expect_meas(88, 18);
`endif
    drive(1, 10);
    drive(0, 2);
    drive(1, 18);
    drive(0, 70);
    drive(1, 10);
    check_eq("t5_drained", exp_q.size(), 0);

    // high phase of exactly MAX_COUNT ticks: edge wins, period saturates
    apply_reset();
    drive(0, 10);
    expect_meas(MAX_COUNT, MAX_COUNT);
    drive(1, MAX_COUNT);
    drive(0, 70);
    check_eq("t6_no_timeout", 32'(timeout), 0);
    check_eq("t6_state_low", 32'(fsm_state), 2);
    expect_meas(100, 30);
    drive(1, 30);
    drive(0, 70);
    drive(1, 10);
    check_eq("t6_timeout_end", 32'(timeout), 0);
    check_eq("exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
